serial_word_loader: RTL and testbench

//  Upstream feeder for the enabled N-bit holding register: collects N serial bits into a word.

---
 rtl/serial_word_loader.sv | 112 +++++++++++
 tb/tb_serial_word_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_loader.sv
// rtl/serial_word_loader.sv - collects N framed serial bits into a word and strobes load_en once per completed frame
module serial_word_loader #(
    parameter int N         = 8,
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     start,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     abort,
    output logic [N-1:0]             word,
    output logic                     load_en,
    output logic                     busy,
    output logic                     frame_err,
    output logic [$clog2(N+1)-1:0]   bit_cnt
);

    localparam int CW = $clog2(N+1);
    // Keep at least one timer bit so TIMEOUT=0 (timeout disabled) still elaborates.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, ERR} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   sr, sr_nxt, sr_shift, word_nxt;
    logic [CW-1:0]  cnt_nxt;
    logic [TW-1:0]  timer, timer_nxt, timer_sat;
    logic [TW:0]    timer_inc;
    logic           timed_out;

    always_comb begin
        if (MSB_FIRST != 0) sr_shift = {sr[N-2:0], bit_in};
        else                sr_shift = {bit_in, sr[N-1:1]};
    end

    // Timer saturates at its all-ones value so it can never wrap back under TIMEOUT.
    always_comb begin
        timer_inc = {1'b0, timer} + (TW+1)'(1);
        timer_sat = (&timer) ? timer : timer_inc[TW-1:0];
        timed_out = (TIMEOUT > 0) && (timer_inc == (TW+1)'(TIMEOUT));
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = bit_cnt;
        timer_nxt = timer;
        word_nxt  = word;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    sr_nxt    = '0;
                    cnt_nxt   = '0;
                    timer_nxt = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (bit_valid) begin
                    sr_nxt    = sr_shift;
                    cnt_nxt   = bit_cnt + CW'(1);
                    timer_nxt = '0;
                    if (bit_cnt == CW'(N-1)) begin
                        word_nxt  = sr_shift;
                        state_nxt = LOAD;
                    end
                end else begin
                    timer_nxt = timer_sat;
                    if (timed_out) state_nxt = ERR;
                end
            end
            LOAD: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            ERR: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            timer   <= '0;
            word    <= '0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            bit_cnt <= cnt_nxt;
            timer   <= timer_nxt;
            word    <= word_nxt;
        end
    end

    assign load_en   = (state == LOAD);
    assign frame_err = (state == ERR);
    assign busy      = (state == SHIFT) || (state == LOAD);

endmodule

// File: tb/tb_serial_word_loader.sv
// tb/tb_serial_word_loader.sv - scoreboard bench for serial_word_loader, MSB-first and LSB-first instances
module tb_serial_word_loader;

    localparam int N  = 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic start = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, abort = 1'b0;

    logic [N-1:0] word_m, word_l;
    logic         load_en_m, load_en_l, busy_m, busy_l, frame_err_m, frame_err_l;
    logic [3:0]   bit_cnt_m, bit_cnt_l;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        bit           is_err;
        logic [N-1:0] wm;
        logic [N-1:0] wl;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [N-1:0] last_m = '0, last_l = '0;

    serial_word_loader #(.N(N), .MSB_FIRST(1), .TIMEOUT(TO)) dut_m (
        .clk(clk), .clr(clr), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
        .abort(abort), .word(word_m), .load_en(load_en_m), .busy(busy_m),
        .frame_err(frame_err_m), .bit_cnt(bit_cnt_m)
    );

    serial_word_loader #(.N(N), .MSB_FIRST(0), .TIMEOUT(TO)) dut_l (
        .clk(clk), .clr(clr), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
        .abort(abort), .word(word_l), .load_en(load_en_l), .busy(busy_l),
        .frame_err(frame_err_l), .bit_cnt(bit_cnt_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected frame outcome.
    always @(negedge clk) begin
        if (!clr) begin
            last_m = '0;
            last_l = '0;
        end else begin
            if (!load_en_m) chk("word_hold_m", word_m, last_m);
            if (!load_en_l) chk("word_hold_l", word_l, last_l);
            if (load_en_m || frame_err_m || load_en_l || frame_err_l) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {load_en_m, frame_err_m, load_en_l, frame_err_l}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_cycle", cyc, mon_e.cyc);
                    chk("load_en_m", load_en_m, !mon_e.is_err);
                    chk("load_en_l", load_en_l, !mon_e.is_err);
                    chk("frame_err_m", frame_err_m, mon_e.is_err);
                    chk("frame_err_l", frame_err_l, mon_e.is_err);
                    if (!mon_e.is_err) begin
                        chk("word_m", word_m, mon_e.wm);
                        chk("word_l", word_l, mon_e.wl);
                    end
                end
            end
            last_m = word_m;
            last_l = word_l;
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_word_m"}, word_m, 0);
        chk({tag, "_word_l"}, word_l, 0);
        chk({tag, "_busy"}, {busy_m, busy_l}, 0);
        chk({tag, "_bit_cnt"}, {bit_cnt_m, bit_cnt_l}, 0);
        chk({tag, "_strobes"}, {load_en_m, load_en_l, frame_err_m, frame_err_l}, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", {busy_m, busy_l}, 0);
            start = 1'b0; bit_valid = 1'(($urandom)); bit_in = 1'($urandom); abort = 1'($urandom);
        end
    endtask

    // mode 0: clean inputs; 1: random ignored inputs; 2: as 1 plus start held in LOAD.
    // seq[N-1] is the first bit sent; gap[i] idle cycles precede bit i; abort_at rides on that bit.
    task automatic run_frame(input logic [N-1:0] seq, input int gap[N], input int abort_at, input int mode);
        exp_t e;
        int   timer;
        @(negedge clk);
        start = 1'b1; bit_in = 1'($urandom);
        bit_valid = (mode != 0) ? 1'($urandom) : 1'b0;
        abort     = (mode != 0) ? 1'($urandom) : 1'b0;
        timer = 0;
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                @(negedge clk);
                chk("gap_bit_cnt", bit_cnt_m, i);
                chk("gap_busy", busy_m, 1);
                start = (mode != 0) ? 1'($urandom) : 1'b0;
                bit_valid = 1'b0; abort = 1'b0; bit_in = 1'($urandom);
                timer++;
                if (timer == TO) begin
                    e.is_err = 1'b1; e.wm = '0; e.wl = '0; e.cyc = cyc + 1;
                    exp_q.push_back(e);
                    @(negedge clk);
                    chk("err_busy", {busy_m, busy_l}, 0);
                    start = 1'b0; bit_valid = 1'b0; abort = 1'b0;
                    return;
                end
            end
            @(negedge clk);
            chk("bit_cnt", bit_cnt_l, i);
            chk("shift_busy", busy_l, 1);
            start = (mode != 0) ? 1'($urandom) : 1'b0;
            bit_valid = 1'b1; bit_in = seq[N-1-i]; abort = (i == abort_at);
            timer = 0;
            if (i == abort_at) begin
                @(negedge clk);
                chk("abort_bit_cnt", {bit_cnt_m, bit_cnt_l}, 0);
                chk("abort_busy", {busy_m, busy_l}, 0);
                start = 1'b0; bit_valid = 1'b0; abort = 1'b0;
                return;
            end
            if (i == N-1) begin
                e.is_err = 1'b0;
                e.wm = seq;
                for (int k = 0; k < N; k++) e.wl[k] = seq[N-1-k];
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        chk("load_bit_cnt", bit_cnt_m, N);
        chk("load_busy", {busy_m, busy_l}, 2'b11);
        start     = (mode == 2) ? 1'b1 : ((mode != 0) ? 1'($urandom) : 1'b0);
        bit_valid = (mode != 0) ? 1'($urandom) : 1'b0;
        abort     = (mode != 0) ? 1'($urandom) : 1'b0;
        bit_in    = 1'($urandom);
    endtask

    task automatic reset_mid_frame();
        @(negedge clk);
        start = 1'b1; bit_valid = 1'b0; abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0; bit_valid = 1'b1; bit_in = 1'($urandom);
        end
        @(negedge clk);
        chk("pre_reset_bit_cnt", bit_cnt_m, 5);
        bit_valid = 1'b0;
        #2 clr = 1'b0;
        #1 chk_idle_outputs("async_reset");
        @(negedge clk);
        #3 clr = 1'b1;
    endtask

    initial begin
        int z[N];
        int g[N];
        int ab;
        logic [N-1:0] seq;
        for (int i = 0; i < N; i++) z[i] = 0;

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        #3 clr = 1'b1;

        run_frame(8'hB2, z, -1, 0);
        idle(2);

        g = z; g[3] = 3;
        run_frame(8'hB2, g, -1, 1);
        idle(1);
        g[3] = 4;
        run_frame(8'hB2, g, -1, 1);
        idle(1);

        run_frame(8'h5A, z, 4, 1);
        run_frame(8'hB2, z, -1, 1);

        reset_mid_frame();
        run_frame(8'hB2, z, -1, 1);

        run_frame(8'h3C, z, -1, 2);
        run_frame(8'hC3, z, -1, 1);
        idle(1);

        for (int f = 0; f < 60; f++) begin
            seq = N'($urandom);
            for (int i = 0; i < N; i++)
                g[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : 0;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N-1)) : -1;
            run_frame(seq, g, ab, int'($urandom_range(1, 2)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end

        idle(4);
        chk("pending_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
